// File: rtl/one_wire_pkg.sv
// Shared definitions for the one-wire transmit path: buffer geometry, timing
// defaults (in clk cycles at 50 MHz) and the sequencer state encoding.
package one_wire_pkg;

  localparam int BUF_DEPTH = 32;
  localparam int BUF_AW    = 5;
  localparam int CNT_W     = 6;
  localparam int TIMER_W   = 16;

  localparam int T_LOW1_DEF     = 300;
  localparam int T_LOW0_DEF     = 3000;
  localparam int T_SLOT_DEF     = 3500;
  localparam int T_RSTL_DEF     = 24000;
  localparam int T_MSP_DEF      = 3500;
  localparam int T_RSTH_DEF     = 24000;
  localparam int DV_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_LOW = 3'd1,
    ST_RST_REL = 3'd2,
    ST_FETCH   = 3'd3,
    ST_WAIT_DV = 3'd4,
    ST_BIT_LOW = 3'd5,
    ST_BIT_REL = 3'd6,
    ST_DONE    = 3'd7
  } ow_state_e;

  // Requests beyond the buffer depth would re-send entries, so cap them.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : c;
  endfunction

endpackage

// File: rtl/one_wire_slot_timer.sv
// Loadable down-counter used for every timed phase of the sequencer.
// A load of N-1 on state entry makes the phase last exactly N cycles.
module one_wire_slot_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/one_wire_tx_sequencer.sv
// Reads bytes from the one-wire byte buffer and sends them LSB-first as 1-Wire
// write slots, optionally preceded by a reset/presence sequence.
// Buffer read handshake: buf_rd_en is a single-cycle request, buf_rd_addr stays
// stable until the matching single-cycle buf_dv, which qualifies buf_data.
module one_wire_tx_sequencer
  import one_wire_pkg::*;
#(
  parameter int T_LOW1     = T_LOW1_DEF,
  parameter int T_LOW0     = T_LOW0_DEF,
  parameter int T_SLOT     = T_SLOT_DEF,
  parameter int T_RSTL     = T_RSTL_DEF,
  parameter int T_MSP      = T_MSP_DEF,
  parameter int T_RSTH     = T_RSTH_DEF,
  parameter int DV_TIMEOUT = DV_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              do_reset,
  input  logic [BUF_AW-1:0] start_addr,
  input  logic [CNT_W-1:0]  byte_count,
  output logic [BUF_AW-1:0] buf_rd_addr,
  output logic              buf_rd_en,
  input  logic [7:0]        buf_data,
  input  logic              buf_dv,
  input  logic              ow_in,
  output logic              ow_drive_low,
  output logic              busy,
  output logic              done,
  output logic              presence,
  output logic              err_no_pres,
  output logic              err_timeout,
  output ow_state_e         state_dbg
);

  // Timer value during RST_REL at which T_MSP cycles have elapsed since release.
  localparam logic [TIMER_W-1:0] PRES_POINT = TIMER_W'(T_RSTH - 1 - T_MSP);

  ow_state_e           state_q, state_d;
  logic [BUF_AW-1:0]   addr_q;
  logic [CNT_W-1:0]    count_q;
  logic [7:0]          shreg_q;
  logic [2:0]          bit_idx_q;
  logic                presence_q, err_no_pres_q, err_timeout_q;
  logic                ow_s1, ow_s2;

  logic                accept, sample_pres, set_nopres, set_timeout, capture, slot_end;
  logic                next_bit;
  logic                timer_load, timer_zero;
  logic [TIMER_W-1:0]  timer_value, timer_count;

  one_wire_slot_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    sample_pres = 1'b0;
    set_nopres  = 1'b0;
    set_timeout = 1'b0;
    capture     = 1'b0;
    slot_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (do_reset)                            state_d = ST_RST_LOW;
          else if (clamp_count(byte_count) == '0)  state_d = ST_DONE;
          else                                     state_d = ST_FETCH;
        end
      end
      ST_RST_LOW: begin
        if (timer_zero) state_d = ST_RST_REL;
      end
      ST_RST_REL: begin
        sample_pres = (timer_count == PRES_POINT);
        if (timer_zero) begin
          // Include a same-cycle sample so T_MSP = T_RSTH-1 still works.
          if (!(presence_q || (sample_pres && !ow_s2))) begin
            set_nopres = 1'b1;
            state_d    = ST_DONE;
          end else if (count_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT_DV;
      end
      ST_WAIT_DV: begin
        if (buf_dv) begin
          capture = 1'b1;
          state_d = ST_BIT_LOW;
        end else if (timer_zero) begin
          set_timeout = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_BIT_LOW: begin
        if (timer_zero) state_d = ST_BIT_REL;
      end
      ST_BIT_REL: begin
        if (timer_zero) begin
          slot_end = 1'b1;
          if (bit_idx_q != 3'd7)      state_d = ST_BIT_LOW;
          else if (count_q == 6'd1)   state_d = ST_DONE;
          else                        state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The bit about to be sent: fresh byte on capture, otherwise the one after the shift.
  assign next_bit   = capture ? buf_data[0] : shreg_q[1];
  assign timer_load = (state_d != state_q);

  always_comb begin
    timer_value = '0;
    case (state_d)
      ST_RST_LOW: timer_value = TIMER_W'(T_RSTL - 1);
      ST_RST_REL: timer_value = TIMER_W'(T_RSTH - 1);
      ST_WAIT_DV: timer_value = TIMER_W'(DV_TIMEOUT - 1);
      ST_BIT_LOW: timer_value = next_bit ? TIMER_W'(T_LOW1 - 1) : TIMER_W'(T_LOW0 - 1);
      ST_BIT_REL: timer_value = shreg_q[0] ? TIMER_W'(T_SLOT - T_LOW1 - 1)
                                           : TIMER_W'(T_SLOT - T_LOW0 - 1);
      default:    timer_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      presence_q    <= 1'b0;
      err_no_pres_q <= 1'b0;
      err_timeout_q <= 1'b0;
      ow_s1         <= 1'b1;
      ow_s2         <= 1'b1;
    end else begin
      state_q <= state_d;
      ow_s1   <= ow_in;
      ow_s2   <= ow_s1;
      if (accept) begin
        addr_q        <= start_addr;
        count_q       <= clamp_count(byte_count);
        presence_q    <= 1'b0;
        err_no_pres_q <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      if (sample_pres && !ow_s2) presence_q    <= 1'b1;
      if (set_nopres)            err_no_pres_q <= 1'b1;
      if (set_timeout)           err_timeout_q <= 1'b1;
      if (capture) begin
        shreg_q   <= buf_data;
        bit_idx_q <= '0;
      end
      if (slot_end) begin
        shreg_q   <= shreg_q >> 1;
        bit_idx_q <= bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
          count_q <= count_q - 6'd1;
          addr_q  <= addr_q + 5'd1;
        end
      end
    end
  end

  assign buf_rd_addr  = addr_q;
  assign buf_rd_en    = (state_q == ST_FETCH);
  assign ow_drive_low = (state_q == ST_RST_LOW) || (state_q == ST_BIT_LOW);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign presence     = presence_q;
  assign err_no_pres  = err_no_pres_q;
  assign err_timeout  = err_timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_one_wire_tx_sequencer.sv
// Directed bench for one_wire_tx_sequencer with a buffer model (dv two cycles
// after rd_en), an open-drain bus model with an optional presence responder.
module tb_one_wire_tx_sequencer;
  import one_wire_pkg::*;

  localparam int T_LOW1     = 3;
  localparam int T_LOW0     = 9;
  localparam int T_SLOT     = 12;
  localparam int T_RSTL     = 16;
  localparam int T_MSP      = 6;
  localparam int T_RSTH     = 14;
  localparam int DV_TIMEOUT = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              do_reset = 1'b0;
  logic [4:0]        start_addr = '0;
  logic [5:0]        byte_count = '0;
  logic [4:0]        buf_rd_addr;
  logic              buf_rd_en;
  logic [7:0]        buf_data = '0;
  logic              buf_dv = 1'b0;
  logic              ow_in;
  logic              ow_drive_low;
  logic              busy, done, presence, err_no_pres, err_timeout;
  ow_state_e         state_dbg;

  one_wire_tx_sequencer #(
    .T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_SLOT(T_SLOT), .T_RSTL(T_RSTL),
    .T_MSP(T_MSP), .T_RSTH(T_RSTH), .DV_TIMEOUT(DV_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .do_reset(do_reset),
    .start_addr(start_addr), .byte_count(byte_count),
    .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en),
    .buf_data(buf_data), .buf_dv(buf_dv), .ow_in(ow_in),
    .ow_drive_low(ow_drive_low), .busy(busy), .done(done),
    .presence(presence), .err_no_pres(err_no_pres), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer model
  logic [7:0] mem [32];
  logic       dv_en = 1'b1;
  logic       rd_p1 = 1'b0;
  always @(posedge clk) begin
    rd_p1    <= buf_rd_en;
    buf_dv   <= rd_p1 & dv_en;
    buf_data <= (rd_p1 & dv_en) ? mem[buf_rd_addr] : 8'h00;
  end

  // bus model: presence pulse after any low run of at least T_RSTL
  logic pres_en = 1'b0;
  int   run_p = 0;
  int   rel_p = 0;
  logic slave_pull;
  always @(posedge clk) begin
    if (ow_drive_low) begin
      run_p <= run_p + 1;
      rel_p <= 0;
    end else begin
      run_p <= 0;
      if (run_p >= T_RSTL)               rel_p <= 1;
      else if (rel_p != 0 && rel_p < 12) rel_p <= rel_p + 1;
      else                               rel_p <= 0;
    end
  end
  assign slave_pull = pres_en && (rel_p >= 1) && (rel_p <= 10);
  assign ow_in      = ~(ow_drive_low | slave_pull);

  // monitors
  int         low_run = 0;
  logic [15:0] low_q[$];
  logic [4:0]  rd_q[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (ow_drive_low) low_run++;
    else if (low_run != 0) begin
      low_q.push_back(16'(low_run));
      low_run = 0;
    end
    if (buf_rd_en) rd_q.push_back(buf_rd_addr);
    if (done) done_cnt++;
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // drivers
  int start_cyc;
  task automatic do_start(input logic [4:0] a, input logic [5:0] n, input logic r);
    @(negedge clk);
    start_addr = a;
    byte_count = n;
    do_reset   = r;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit ok);
    ok   = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok   = 1'b1;
        dcyc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [5:0] cnt;
    bit         rst;
    bit         pull;
    bit         dv;
    int         n_rd;
    bit         pres;
    bit         nopres;
    bit         tmo;
    int         dur;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          dcyc;
    bit          ok;
    int          d0;
    logic [4:0]  ea;
    logic [7:0]  b;

    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 8'h5A);
    mem[3] = 8'hA5;

    //            addr  cnt  rst pull dv  n_rd pres nop tmo dur
    vecs[0] = '{5'd3,  6'd1,  1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 100};
    vecs[1] = '{5'd5,  6'd2,  1'b1, 1'b1, 1'b1, 2,  1'b1, 1'b0, 1'b0, 229};
    vecs[2] = '{5'd7,  6'd3,  1'b1, 1'b0, 1'b1, 0,  1'b0, 1'b1, 1'b0, 31};
    vecs[3] = '{5'd30, 6'd4,  1'b0, 1'b0, 1'b1, 4,  1'b0, 1'b0, 1'b0, 397};
    vecs[4] = '{5'd9,  6'd2,  1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8};
    vecs[5] = '{5'd0,  6'd0,  1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1};
    vecs[6] = '{5'd12, 6'd40, 1'b0, 1'b0, 1'b1, 32, 1'b0, 1'b0, 1'b0, 3169};
    vecs[7] = '{5'd20, 6'd0,  1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b0, 31};

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_drive_low", int'(ow_drive_low), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_presence",  int'(presence), 0);
    check("rst_no_pres",   int'(err_no_pres), 0);
    check("rst_timeout",   int'(err_timeout), 0);
    check("rst_rd_en",     int'(buf_rd_en), 0);
    check("rst_state",     int'(state_dbg), int'(ST_IDLE));

    // table-driven runs
    foreach (vecs[v]) begin
      pres_en = vecs[v].pull;
      dv_en   = vecs[v].dv;
      low_q.delete();
      rd_q.delete();
      exp_q.delete();
      if (vecs[v].rst) exp_q.push_back(16'(T_RSTL));
      if (!vecs[v].tmo && !vecs[v].nopres) begin
        for (int i = 0; i < vecs[v].n_rd; i++) begin
          ea = vecs[v].addr + 5'(i);
          b  = mem[ea];
          for (int k = 0; k < 8; k++) exp_q.push_back(b[k] ? 16'(T_LOW1) : 16'(T_LOW0));
        end
      end

      do_start(vecs[v].addr, vecs[v].cnt, vecs[v].rst);
      check($sformatf("v%0d_busy", v), int'(busy), (vecs[v].dur > 1) ? 1 : 0);
      wait_done(5000, dcyc, ok);
      check($sformatf("v%0d_done_seen", v), int'(ok), 1);
      check($sformatf("v%0d_duration", v), dcyc - start_cyc, vecs[v].dur);
      check($sformatf("v%0d_presence", v), int'(presence), int'(vecs[v].pres));
      check($sformatf("v%0d_no_pres", v), int'(err_no_pres), int'(vecs[v].nopres));
      check($sformatf("v%0d_timeout", v), int'(err_timeout), int'(vecs[v].tmo));
      @(negedge clk);
      check($sformatf("v%0d_done_single", v), int'(done), 0);
      check($sformatf("v%0d_idle_busy", v), int'(busy), 0);
      check($sformatf("v%0d_idle_bus", v), int'(ow_drive_low), 0);
      check($sformatf("v%0d_rd_count", v), rd_q.size(), vecs[v].n_rd);
      for (int i = 0; i < rd_q.size() && i < vecs[v].n_rd; i++) begin
        ea = vecs[v].addr + 5'(i);
        check($sformatf("v%0d_rd_addr%0d", v, i), int'(rd_q[i]), int'(ea));
      end
      check($sformatf("v%0d_slot_count", v), low_q.size(), exp_q.size());
      for (int i = 0; i < low_q.size() && i < exp_q.size(); i++)
        check($sformatf("v%0d_low%0d", v, i), int'(low_q[i]), int'(exp_q[i]));
    end
    pres_en = 1'b0;
    dv_en   = 1'b1;

    // reset during BIT_LOW releases the bus on the next edge
    do_start(5'd3, 6'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ow_drive_low) ok = 1'b1;
      else @(negedge clk);
    end
    check("midrst_low_seen", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_bus", int'(ow_drive_low), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_state", int'(state_dbg), int'(ST_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // start while busy and start in the DONE cycle are both ignored
    rd_q.delete();
    d0 = done_cnt;
    do_start(5'd3, 6'd1, 1'b0);
    repeat (10) @(negedge clk);
    start_addr = 5'd5;
    byte_count = 6'd5;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    wait_done(5000, dcyc, ok);
    check("busy_start_done_seen", int'(ok), 1);
    check("busy_start_duration", dcyc - start_cyc, 100);
    start_addr = 5'd0;
    byte_count = 6'd2;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    check("done_cycle_start_busy", int'(busy), 0);
    repeat (150) @(negedge clk);
    check("ignored_start_done_cnt", done_cnt - d0, 1);
    check("ignored_start_rd_count", rd_q.size(), 1);
    check("ignored_start_idle", int'(state_dbg), int'(ST_IDLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
